// File: rtl/program_loader.sv
// Front-panel program loader: assembles a byte-streamed program image and
// hands it to the relay computer through a four-phase loadMem/loadMemComplete handshake.
module program_loader #(
    parameter int IMAGE_BYTES = 15,
    parameter int TIMEOUT     = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         byte_ready,
    output logic [IMAGE_BYTES-1:0][7:0]  initial_memory,
    output logic                         loadMem,
    input  logic                         loadMemComplete,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   dbg_state
);

    localparam int CNT_W = $clog2(IMAGE_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMAGE_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;

    // Handshake strobes decode straight from the state register, so reset
    // drops loadMem asynchronously and byte_ready never depends on byte_valid.
    // A byte moves when byte_valid and byte_ready are both high at a rising edge.
    assign byte_ready = (state == COLLECT);
    assign loadMem    = (state == LOAD);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            tmo            <= '0;
            initial_memory <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        error <= 1'b0;
                        state <= COLLECT;
                    end
                end

                COLLECT: begin
                    // A restart wins over a byte offered in the same cycle.
                    if (start) begin
                        cnt   <= '0;
                        error <= 1'b0;
                    end else if (byte_valid) begin
                        for (int i = 0; i < IMAGE_BYTES; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                initial_memory[i] <= byte_in;
                            end
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            tmo   <= '0;
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (loadMemComplete) begin
                        tmo   <= '0;
                        state <= RELEASE;
                    end else if (tmo == TMO_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                RELEASE: begin
                    if (!loadMemComplete) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tmo == TMO_MAX) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized byte streams and acknowledge timing,
// with load outcomes predicted from the byte list and checked by a monitor.
module tb_program_loader;

    localparam int NB  = 15;
    localparam int TMO = 255;
    localparam int W   = 2 + 9 + 9 + NB * 8;
    localparam logic [1:0] EV_DONE = 2'b01;
    localparam logic [1:0] EV_ERR  = 2'b10;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic [NB-1:0][7:0] initial_memory;
    logic               loadMem;
    logic               loadMemComplete;
    logic               busy;
    logic               done;
    logic               error;
    logic [1:0]         dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // Entry: {event kind, loadMem high cycles, RELEASE cycles, image}
    logic [W-1:0] exp_q[$];
    logic [7:0]   tx[$];

    program_loader #(.IMAGE_BYTES(NB), .TIMEOUT(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .initial_memory  (initial_memory),
        .loadMem         (loadMem),
        .loadMemComplete (loadMemComplete),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .dbg_state       (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, required event never seen", name);
    endtask

    function automatic logic [NB*8-1:0] img_of_tx();
        logic [NB*8-1:0] r = '0;
        foreach (tx[i]) r[i*8 +: 8] = tx[i];
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input logic [1:0] kind, input int ll, input int rl,
                                        input logic [NB*8-1:0] img);
        return {kind, 9'(ll), 9'(rl), img};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic offer, input logic [7:0] b);
        start      = 1'b1;
        byte_valid = offer;
        byte_in    = b;
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic send_bytes(input int gap_mode, output int cycles);
        cycles = 0;
        foreach (tx[i]) begin
            bit acc   = 1'b0;
            int guard = 0;
            if (gap_mode == 1 && i > 0) begin
                byte_valid = 1'b0;
                tick();
                cycles++;
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    byte_valid = 1'b0;
                    tick();
                    cycles++;
                end
            end
            byte_in    = tx[i];
            byte_valid = 1'b1;
            while (!acc && guard < 50) begin
                acc = byte_ready;
                tick();
                cycles++;
                guard++;
            end
            if (!acc) timeout_fail("byte_accept");
        end
        byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic respond(input int d_up, input int d_down);
        int g = 0;
        while (!loadMem && g < 20) begin
            tick();
            g++;
        end
        if (!loadMem) begin
            timeout_fail("loadmem_request");
        end else begin
            repeat (d_up) tick();
            loadMemComplete = 1'b1;
            repeat (d_down) tick();
            loadMemComplete = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound);
        int g = 0;
        while (busy && g < bound) begin
            tick();
            g++;
        end
        chk1("return_idle", busy, 1'b0);
        tick();
    endtask

    task automatic wait_error(input int bound);
        int g = 0;
        while (!error && g < bound) begin
            tick();
            g++;
        end
        chk1("error_raised", error, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_byte_ready"}, byte_ready, 1'b0);
        chk1({tag, "_loadmem"}, loadMem, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_error"}, error, 1'b0);
        chki({tag, "_image"}, initial_memory, '0);
    endtask

    // Full image, random gaps and acknowledge timing, expected to end in done.
    task automatic normal_load(input int gap_mode);
        int cyc;
        int du = $urandom_range(0, 6);
        int dd = $urandom_range(1, 5);
        send_bytes(gap_mode, cyc);
        chk1("loadmem_after_last", loadMem, 1'b1);
        chk1("ready_after_last", byte_ready, 1'b0);
        exp_q.push_back(mk(EV_DONE, du + 1, dd, img_of_tx()));
        respond(du, dd);
        wait_idle(50);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int cur = 0;
        int last_len = 0;
        int rel = 0;
        bit in_rel = 1'b0;
        bit prev_lm = 1'b0;
        bit prev_err = 1'b0;
        bit prev_done = 1'b0;
        bit ev_done;
        bit ev_err;
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (loadMem) begin
                cur++;
            end else if (prev_lm) begin
                last_len = cur;
                cur      = 0;
                in_rel   = busy;
                rel      = busy ? 1 : 0;
            end else if (in_rel && busy) begin
                rel++;
            end
            if (prev_done) chk1("done_one_cycle", done, 1'b0);
            ev_done = done && !prev_done;
            ev_err  = error && !prev_err;
            if (ev_done || ev_err) begin
                if (exp_q.size() == 0) begin
                    chkn("unexpected_event", int'({ev_err, ev_done}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chkn("event_kind", int'({ev_err, ev_done}), int'(e[W-1 -: 2]));
                    chki("image", initial_memory, e[NB*8-1:0]);
                    chkn("loadmem_cycles", last_len, int'(e[W-3 -: 9]));
                    chkn("release_cycles", rel, int'(e[NB*8+8 -: 9]));
                    chk1("idle_at_event", busy, 1'b0);
                end
            end
            if (!busy) in_rel = 1'b0;
            prev_lm   = loadMem;
            prev_err  = error;
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int cyc;
        int g;
        reset           = 1'b1;
        start           = 1'b0;
        byte_valid      = 1'b0;
        byte_in         = 8'h00;
        loadMemComplete = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Reset in the middle of a collection.
        pulse_start(1'b0, 8'h00);
        chk1("ready_after_start", byte_ready, 1'b1);
        fill_random(5);
        send_bytes(0, cyc);
        #2 reset = 1'b1;
        #1;
        chk1("async_reset_ready", byte_ready, 1'b0);
        chki("async_reset_image", initial_memory, '0);
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        // Back-to-back 0x01..0x0F, ack 3 cycles after loadMem, release 2 later.
        pulse_start(1'b0, 8'h00);
        chk1("ready_after_start", byte_ready, 1'b1);
        tx.delete();
        for (int i = 0; i < NB; i++) tx.push_back(8'(i + 1));
        send_bytes(0, cyc);
        chkn("back_to_back_cycles", cyc, NB);
        chk1("loadmem_after_last", loadMem, 1'b1);
        chk1("ready_after_last", byte_ready, 1'b0);
        exp_q.push_back(mk(EV_DONE, 4, 2, img_of_tx()));
        respond(3, 2);
        wait_idle(50);

        // Gapped stream, restart after 7 bytes with a byte offered alongside start.
        pulse_start(1'b0, 8'h00);
        fill_random(7);
        send_bytes(1, cyc);
        pulse_start(1'b1, 8'h55);
        chk1("ready_after_restart", byte_ready, 1'b1);
        tx.delete();
        for (int i = 0; i < NB; i++) tx.push_back(8'(8'hA0 + i));
        normal_load(1);

        // Random images with random gaps and acknowledge timing.
        for (int k = 0; k < 4; k++) begin
            pulse_start(1'b0, 8'h00);
            fill_random(NB);
            normal_load(2);
        end

        // Acknowledge never arrives: loadMem held TIMEOUT+1 cycles, then error.
        pulse_start(1'b0, 8'h00);
        fill_random(NB);
        send_bytes(2, cyc);
        chk1("loadmem_after_last", loadMem, 1'b1);
        exp_q.push_back(mk(EV_ERR, TMO + 1, 0, img_of_tx()));
        wait_error(400);
        chk1("timeout_idle", busy, 1'b0);
        chk1("timeout_loadmem_low", loadMem, 1'b0);
        tick();
        pulse_start(1'b0, 8'h00);
        chk1("start_clears_error", error, 1'b0);
        chk1("ready_after_error_start", byte_ready, 1'b1);

        // Acknowledge stuck high in RELEASE; start pulses in LOAD and RELEASE ignored.
        fill_random(NB);
        send_bytes(2, cyc);
        chk1("loadmem_after_last", loadMem, 1'b1);
        exp_q.push_back(mk(EV_ERR, 5, TMO + 1, img_of_tx()));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        loadMemComplete = 1'b1;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_error(400);
        loadMemComplete = 1'b0;
        tick();
        tick();
        pulse_start(1'b0, 8'h00);
        chk1("start_clears_error2", error, 1'b0);

        // Reset during LOAD drops loadMem at once and clears the image.
        fill_random(NB);
        send_bytes(0, cyc);
        chk1("loadmem_after_last", loadMem, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk1("reset_in_load_loadmem", loadMem, 1'b0);
        chki("reset_in_load_image", initial_memory, '0);
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("post_load_reset");

        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chkn("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
